serv_dbus_responder: RTL and testbench
======================================

Name: serv_dbus_responder

Overview:
- Wishbone-classic data-bus target that answers the SERV core's dbus master, i.e. the address/data produced by the buffer register and memory interface.
- Backs a word-organised, byte-writable RAM of DEPTH bytes.
- Inserts a programmable number of wait states, then returns one single-cycle ack per request.
- Used as the data-side memory in simulation tops and small FPGA builds.

Parameters:
- DEPTH, 256, RAM size in bytes; power of two, ≥ 8.
- AW, $clog2(DEPTH), byte-address width actually decoded.
- WAIT_CYCLES, 0, extra cycles between accepting a request and acking it (0..15).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active low.
- i_wb_adr  in  32  byte address; bits [1:0] are ignored (master always sends word-aligned).
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte lane enables; bit n covers dat[8n+7:8n].
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_cyc  in  1  request valid; held by the master until ack.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  single-cycle completion.
- o_wb_err  out  1  error completion (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async assert, sync deassert internally):
  - state = IDLE, o_wb_ack = 0, o_wb_rdt = 0, o_wb_err = 0, wait counter = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If i_wb_cyc = 1, latch adr[AW-1:2], we, sel, dat.
  - Go to WAIT if WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES-1); otherwise go to RESP.
- WAIT:
  - Counter decrements each cycle; at 0 go to RESP.
  - If i_wb_cyc drops during WAIT, abort to IDLE: no write, no ack.
- RESP (one cycle):
  - o_wb_ack = 1.
  - Write: commit the enabled bytes on the edge entering RESP.
  - Read: o_wb_rdt = RAM word, registered on the edge entering RESP.
  - Next state is always IDLE.
- o_wb_rdt outside RESP = 0, so the serial load path never sees stale data.
- Latency from cyc rising to ack = 1 + WAIT_CYCLES cycles. WAIT_CYCLES = 0 gives ack on the second cycle of cyc.
- Back-to-back: the master clears cyc on the ack edge. A cyc still high in the cycle after RESP is treated as a new request. At most one ack per 2 + WAIT_CYCLES cycles.
- sel = 4'b0000 write: acked, RAM unchanged.
- Address beyond DEPTH (no optional feature): wraps modulo DEPTH; upper bits are ignored.
- Reset asserted mid-WAIT or mid-RESP: the transaction is dropped. Any write already committed on a prior edge stays; the RESP-entry write does not occur if reset is active at that edge.
- Write and read in the same cycle cannot happen (single port, one request at a time).

Optional Feature:
- Macro: SERV_DBUS_RESPONDER_ERR_EN.
- Defined:
  - Any i_wb_adr[31:AW] ≠ 0 completes with o_wb_err = 1 (not ack) in the RESP cycle.
  - No RAM write; o_wb_rdt = 0.
  - o_wb_err resets to 0.
- Undefined: o_wb_err tied 0; addresses alias as above.

Decomposition:
- Package serv_dbus_pkg:
  - state enum {IDLE, WAIT, RESP};
  - localparam for wait-counter width (4);
  - byte-lane count (4).
- Sub-module serv_dbus_ram: DEPTH/4 × 32 synchronous single-port RAM with 4 byte-write enables and registered read. The top holds only the FSM, counter, latching and response muxing.

Test Plan:
- WAIT_CYCLES=0: write adr 0x10, dat 0xDEADBEEF, sel 4'hF; then read adr 0x10 -> ack 1 cycle after cyc each time, rdt = 0xDEADBEEF in the ack cycle, 0 afterwards.
- Byte lanes: word 0x20 = 0x11223344, write sel 4'b0100 dat 0xAABBCCDD; read -> 0x11BB3344.
- WAIT_CYCLES=3: read request -> ack exactly 4 cycles after cyc rises. Drop cyc after 2 cycles of a write -> no ack, and a later read shows the old value.
- Alias (feature off, DEPTH=256): write 0x104 = 0x5A5A5A5A; read 0x004 -> 0x5A5A5A5A. Feature on: same write -> err = 1, ack = 0, and read 0x004 unchanged.
- Reset: assert i_rst_n = 0 mid-WAIT -> ack/err/rdt go 0 immediately (async), state IDLE. After release, the next request completes normally.
- Back-to-back: hold cyc continuously for 3 reads (WAIT_CYCLES=0) -> acks on cycles 2, 4 and 6, never on adjacent cycles.

Source files
------------

// File: rtl/serv_dbus_pkg.sv
// Shared types and constants for the SERV dbus responder.
package serv_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W     = 4;
  localparam int NUM_LANES = 4;

  // Byte-lane write strobes; blocked requests (reads, errors) strobe nothing.
  function automatic logic [NUM_LANES-1:0] lane_we(input logic [NUM_LANES-1:0] sel,
                                                   input logic                 we,
                                                   input logic                 blk);
    return sel & {NUM_LANES{we & ~blk}};
  endfunction

endpackage

// File: rtl/serv_dbus_ram.sv
// Word-organised single-port RAM, one byte-wide array per lane, registered read.
module serv_dbus_ram
  import serv_dbus_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int WW    = $clog2(DEPTH) - 2
) (
  input  logic                      clk_i,
  input  logic                      en_i,
  input  logic [NUM_LANES-1:0]      we_i,
  input  logic [WW-1:0]             addr_i,
  input  logic [NUM_LANES-1:0][7:0] wdat_i,
  output logic [NUM_LANES-1:0][7:0] rdat_o
);

  localparam int NWORDS = DEPTH / 4;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [NWORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        if (we_i[l]) mem[addr_i] <= wdat_i[l];
        rd_q <= mem[addr_i];
      end
    end

    assign rdat_o[l] = rd_q;
  end

endmodule

// File: rtl/serv_dbus_responder.sv
// Wishbone-classic dbus target for SERV: wait states, single-cycle ack, byte-writable RAM.
// Optional bus error on out-of-range address when SERV_DBUS_RESPONDER_ERR_EN is defined.
module serv_dbus_responder
  import serv_dbus_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int AW          = $clog2(DEPTH),
  parameter int WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [1:0]       rst_sync_q;
  logic             rst_n_int;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-3:0]    adr_q;
  logic             we_q, err_q;
  logic [3:0]       sel_q;
  logic [31:0]      dat_q;

  logic             bus_err, go_resp;
  logic [AW-3:0]    cur_adr;
  logic             cur_we, cur_err;
  logic [3:0]       cur_sel;
  logic [31:0]      cur_dat;
  logic [NUM_LANES-1:0][7:0] ram_rdat;

  // Assert asynchronously, release on the clock so the FSM leaves reset cleanly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

`ifdef SERV_DBUS_RESPONDER_ERR_EN
  assign bus_err = |i_wb_adr[31:AW];
  logic unused_adr;
  assign unused_adr = ^i_wb_adr[1:0];
`else
  assign bus_err = 1'b0;
  logic unused_adr;
  assign unused_adr = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};
`endif

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE && i_wb_cyc) begin
      adr_q <= i_wb_adr[AW-1:2];
      we_q  <= i_wb_we;
      sel_q <= i_wb_sel;
      dat_q <= i_wb_dat;
      err_q <= bus_err;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wb_cyc) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            go_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM access happens on the edge entering RESP; with no wait states that
  // edge is the same one that latches the request, so take it straight off the bus.
  assign cur_adr = (state_q == IDLE) ? i_wb_adr[AW-1:2] : adr_q;
  assign cur_we  = (state_q == IDLE) ? i_wb_we          : we_q;
  assign cur_sel = (state_q == IDLE) ? i_wb_sel         : sel_q;
  assign cur_dat = (state_q == IDLE) ? i_wb_dat         : dat_q;
  assign cur_err = (state_q == IDLE) ? bus_err          : err_q;

  serv_dbus_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i  (i_clk),
    .en_i   (go_resp & rst_n_int),
    .we_i   (lane_we(cur_sel, cur_we, cur_err)),
    .addr_i (cur_adr),
    .wdat_i (cur_dat),
    .rdat_o (ram_rdat)
  );

  assign o_wb_ack = (state_q == RESP) & ~err_q;
`ifdef SERV_DBUS_RESPONDER_ERR_EN
  assign o_wb_err = (state_q == RESP) & err_q;
`else
  assign o_wb_err = 1'b0;
`endif
  assign o_wb_rdt = ((state_q == RESP) && !we_q && !err_q) ? ram_rdat : '0;

endmodule

// File: tb/tb_serv_dbus_responder.sv
// Bench: two responders (0 and 3 wait states) against a byte-array memory model.
module tb_serv_dbus_responder;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0][31:0] adr, dat, rdt;
  logic [1:0][3:0]  sel;
  logic [1:0]       we, cyc, ack, err;

  int tests = 0;
  int fails = 0;
  logic [7:0] mm [2][256];

  always #5 clk = ~clk;

  serv_dbus_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]), .i_wb_sel(sel[0]),
    .i_wb_we(we[0]), .i_wb_cyc(cyc[0]), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]));

  serv_dbus_responder #(.DEPTH(256), .WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]), .i_wb_sel(sel[1]),
    .i_wb_we(we[1]), .i_wb_cyc(cyc[1]), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]));

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic m_err(input logic [31:0] a);
`ifdef SERV_DBUS_RESPONDER_ERR_EN
    return (a >> 8) != 0;
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic logic [31:0] m_rd(input int d, input logic [31:0] a);
    int b;
    b = int'(a % 256) & ~3;
    return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
  endfunction

  task automatic m_wr(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
    int b;
    b = int'(a % 256) & ~3;
    for (int l = 0; l < 4; l++)
      if (s[l]) mm[d][b+l] = v[8*l +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request: latency, completion type and read data against the model.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] v,
                     input logic [3:0] s, input string tag, output logic [31:0] rd);
    logic        e;
    logic [31:0] exp_rd;
    int          n;
    e      = m_err(a);
    exp_rd = e ? 32'h0 : m_rd(d, a);
    @(posedge clk); #1;
    adr[d] = a; dat[d] = v; sel[d] = s; we[d] = w; cyc[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(ack[d] || err[d]) && n < 40) begin
      n++;
      @(negedge clk);
    end
    rd = rdt[d];
    chk({tag, " latency"}, n, 1 + wc(d));
    chk({tag, " ack"}, {31'b0, ack[d]}, {31'b0, !e});
    chk({tag, " err"}, {31'b0, err[d]}, {31'b0, e});
    if (!w) chk({tag, " rdt"}, rd, exp_rd);
    if (w && !e) m_wr(d, a, v, s);
    @(posedge clk); #1;
    cyc[d] = 1'b0;
    @(negedge clk);
    chk({tag, " ack after"}, {31'b0, ack[d]}, 32'h0);
    chk({tag, " rdt after"}, rdt[d], 32'h0);
  endtask

  initial begin
    logic [31:0] rd, pre, a, v;
    logic [31:0] b2b [3];
    logic        w, saw;
    int          k;

    adr = '0; dat = '0; sel = '0; we = '0; cyc = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset ack", {31'b0, ack[d]}, 32'h0);
      chk("reset err", {31'b0, err[d]}, 32'h0);
      chk("reset rdt", rdt[d], 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Give every word a known value so the model is fully defined.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        txn(d, 1'b1, i * 4, $urandom, 4'hF, "preload", rd);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "w0 10", rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, "r0 10", rd);
    chk("deadbeef", rd, 32'hDEADBEEF);

    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "w0 20", rd);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0100, "w0 20 lane2", rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, "r0 20", rd);
    chk("byte lane", rd, 32'h11BB3344);
    txn(0, 1'b1, 32'h24, 32'hCAFEF00D, 4'h0, "w0 sel0", rd);
    txn(0, 1'b0, 32'h24, 32'h0, 4'hF, "r0 sel0", rd);

    txn(1, 1'b0, 32'h10, 32'h0, 4'hF, "r3 latency", rd);
    txn(1, 1'b0, 32'h30, 32'h0, 4'hF, "r3 30 pre", pre);
    @(posedge clk); #1;
    adr[1] = 32'h30; dat[1] = ~pre; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 cyc[1] = 1'b0;
    saw = 1'b0;
    repeat (6) begin @(negedge clk); saw |= ack[1] | err[1]; end
    chk("abort no ack", {31'b0, saw}, 32'h0);
    txn(1, 1'b0, 32'h30, 32'h0, 4'hF, "r3 after abort", rd);
    chk("abort unchanged", rd, pre);

    txn(0, 1'b0, 32'h04, 32'h0, 4'hF, "r0 04 pre", pre);
    txn(0, 1'b1, 32'h104, 32'h5A5A5A5A, 4'hF, "w0 alias", rd);
    txn(0, 1'b0, 32'h04, 32'h0, 4'hF, "r0 alias", rd);
`ifdef SERV_DBUS_RESPONDER_ERR_EN
    chk("alias blocked", rd, pre);
`else
    chk("alias wrap", rd, 32'h5A5A5A5A);
`endif

    // Reset while dut0 is acking and dut3 is waiting on a write.
    @(posedge clk); #1;
    adr[0] = 32'h44; we[0] = 1'b0; sel[0] = 4'hF; cyc[0] = 1'b1;
    adr[1] = 32'h40; dat[1] = 32'h0BADF00D; we[1] = 1'b1; sel[1] = 4'hF; cyc[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset ack", {31'b0, ack[0]}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst ack0", {31'b0, ack[0]}, 32'h0);
    chk("rst rdt0", rdt[0], 32'h0);
    chk("rst ack3", {31'b0, ack[1]}, 32'h0);
    chk("rst err3", {31'b0, err[1]}, 32'h0);
    adr[0] = 32'h48; dat[0] = 32'h12345678; we[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 cyc = '0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    txn(1, 1'b0, 32'h40, 32'h0, 4'hF, "r3 after rst", rd);
    txn(0, 1'b0, 32'h48, 32'h0, 4'hF, "r0 after rst", rd);
    txn(0, 1'b1, 32'h48, 32'h600DCAFE, 4'hF, "w0 after rst", rd);
    txn(0, 1'b0, 32'h48, 32'h0, 4'hF, "r0 post", rd);
    chk("post reset rw", rd, 32'h600DCAFE);

    // Back-to-back reads with cyc held: acks only on every other cycle.
    b2b[0] = 32'h10; b2b[1] = 32'h20; b2b[2] = 32'h48;
    @(posedge clk); #1;
    adr[0] = b2b[0]; we[0] = 1'b0; sel[0] = 4'hF; cyc[0] = 1'b1;
    k = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk($sformatf("b2b ack c%0d", n), {31'b0, ack[0]}, {31'b0, (n == 1 || n == 3 || n == 5)});
      saw = ack[0];
      if (saw) begin
        chk($sformatf("b2b rdt %0d", k), rdt[0], m_rd(0, b2b[k]));
        k++;
      end
      @(posedge clk); #1;
      if (saw) begin
        if (k == 3) cyc[0] = 1'b0;
        else        adr[0] = b2b[k];
      end
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 30; i++) begin
        a = {(($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0), 6'($urandom), 2'($urandom)};
        v = $urandom;
        w = 1'($urandom);
        txn(d, w, a, v, 4'($urandom), $sformatf("rand d%0d #%0d", d, i), rd);
      end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
